modport_alu: RTL and testbench
==============================

Name: modport_alu

Overview:
- Registered N-bit arithmetic/logic unit with operand-valid qualifiers, a clock enable and error/flag outputs.
- Driven from the ALU agent's driver clocking block and sampled by its monitor.
- Arithmetic mode supports add/sub with carry, inc/dec, compare and two multiply forms.
- Logic mode supports bitwise ops, single-bit shifts and rotate-by-OPB.

Parameters:
- N, 8, operand width; RES is N+1 bits.
- M, 4, command width.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  reset.
- CE  in  1  clock enable; 0 freezes all outputs and internal state.
- MODE  in  1  1 = arithmetic, 0 = logic.
- CMD  in  M  operation code.
- INP_VALID  in  2  bit0 = OPA valid, bit1 = OPB valid.
- OPA  in  N  operand A, unsigned.
- OPB  in  N  operand B, unsigned.
- CIN  in  1  carry/borrow input.
- RES  out  N+1  result.
- COUT  out  1  carry out.
- OFLOW  out  1  underflow/overflow.
- E  out  1  compare: A == B.
- G  out  1  compare: A > B.
- L  out  1  compare: A < B.
- ERR  out  1  illegal command, operand or valid combination.

Behaviour:
- Clock and reset: one clock, CLK; reset RST is asynchronous and active-low.
- Reset values: all outputs and internal state 0; any multiply in flight is discarded.
- Issue and latency: an op issues on a CLK edge with CE=1 and INP_VALID!=00. Results register at that edge (latency 1), except multiplies (latency 2).
- Flag clearing: every new result clears all flags not defined for that op, and clears RES when RES is not defined.
- INP_VALID=00 with CE=1: no op; outputs hold.
- CE=0: outputs and the multiply pipeline hold; the assertion requires all outputs stable one cycle after CE low.
- Operand requirements:
  - A-only ops require INP_VALID[0]: INC_A, DEC_A, NOT_A, SHR1_A, SHL1_A.
  - B-only ops require INP_VALID[1]: INC_B, DEC_B, NOT_B, SHR1_B, SHL1_B.
  - All other ops require 11.
  - A violation gives ERR=1, RES=0, other flags 0.
- Arithmetic (MODE=1), RES is zero-extended to N+1 bits:
  - 0 ADD: A+B; COUT = sum bit N.
  - 1 SUB: A-B; OFLOW = (A<B).
  - 2 ADD_CIN: A+B+CIN; COUT = bit N.
  - 3 SUB_CIN: A-B-CIN; OFLOW = (A < B+CIN).
  - 4 INC_A: A+1. 5 DEC_A: A-1. 6 INC_B: B+1. 7 DEC_B: B-1. All four use N+1-bit modulo arithmetic and set no flags.
  - 8 CMP: exactly one of E/G/L = 1; RES=0.
  - 9 MUL_INC: (A+1)*(B+1), truncated to N+1 bits, latency 2.
  - 10 MUL_SHL: (A<<1)*B, truncated to N+1 bits, latency 2.
  - 11-15: ERR=1.
- Logic (MODE=0), RES[N]=0 unless noted:
  - 0 AND, 1 NAND, 2 OR, 3 NOR, 4 XOR, 5 XNOR.
  - 6 NOT_A, 7 NOT_B.
  - 8 SHR1_A, 9 SHL1_A, 10 SHR1_B, 11 SHL1_B. Shifts are N-bit, the vacated bit is 0, and the shifted-out bit is discarded.
  - 12 ROL_A_B and 13 ROR_A_B: rotate A by OPB[log2N-1:0]. If any OPB bit above log2N-1 is set: ERR=1, RES still = rotation.
  - 14-15: ERR=1.
- Multiply timing:
  - At the issue edge, the product is computed into an internal stage and outputs hold.
  - The result appears on the next CE=1 edge.
  - Inputs presented on the edge that completes a multiply are ignored.
- Mid-operation reset: aborts instantly, outputs go to 0 asynchronously.

Decomposition:
- Shared package/defines: N, M, the arithmetic and logic command enumerations, and the INP_VALID encoding constants.
- One natural sub-module, modport_alu_mul: 2-stage multiply datapath with hold-on-CE.

Test Plan:
- Reset then ADD: RST 0→1; MODE=1, CMD=0, INP_VALID=11, A=200, B=100 → next edge RES=300, COUT=1, ERR=0.
- SUB_CIN underflow: A=5, B=5, CIN=1 → RES=0x1FF (9-bit wrap), OFLOW=1.
- CMP: A=7, B=9 → L=1, E=0, G=0, RES=0. Then A=B=3 → E=1 only.
- MUL_INC: A=3, B=4 → RES holds one edge, then RES=20 on the second edge. Drop CE during the second cycle → RES stays 0 until CE returns, then RES=20.
- Errors:
  - INC_B with INP_VALID=01 → ERR=1, RES=0.
  - MODE=0, CMD=14 → ERR=1.
  - ROL with A=8'h81, B=8'h11 → RES=8'h03, ERR=1.
- CE hold: after a valid XOR result (A=F0, B=0F → RES=FF), CE=0 with changing inputs for 3 cycles → all outputs unchanged; asynchronous RST low mid-hold → all outputs 0 immediately.

Source files
------------

// File: rtl/modport_alu_pkg.sv
// Shared widths, command encodings and operand-valid codes for modport_alu.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package modport_alu_pkg;

  localparam int ALU_N = 8;
  localparam int ALU_M = 4;

  // INP_VALID encodings: bit0 qualifies OPA, bit1 qualifies OPB
  localparam logic [1:0] IV_NONE = 2'b00;
  localparam logic [1:0] IV_A    = 2'b01;
  localparam logic [1:0] IV_B    = 2'b10;
  localparam logic [1:0] IV_AB   = 2'b11;

  typedef enum logic [ALU_M-1:0] {
    A_ADD     = 4'd0,
    A_SUB     = 4'd1,
    A_ADD_CIN = 4'd2,
    A_SUB_CIN = 4'd3,
    A_INC_A   = 4'd4,
    A_DEC_A   = 4'd5,
    A_INC_B   = 4'd6,
    A_DEC_B   = 4'd7,
    A_CMP     = 4'd8,
    A_MUL_INC = 4'd9,
    A_MUL_SHL = 4'd10
  } arith_cmd_e;

  typedef enum logic [ALU_M-1:0] {
    L_AND    = 4'd0,
    L_NAND   = 4'd1,
    L_OR     = 4'd2,
    L_NOR    = 4'd3,
    L_XOR    = 4'd4,
    L_XNOR   = 4'd5,
    L_NOT_A  = 4'd6,
    L_NOT_B  = 4'd7,
    L_SHR1_A = 4'd8,
    L_SHL1_A = 4'd9,
    L_SHR1_B = 4'd10,
    L_SHL1_B = 4'd11,
    L_ROL    = 4'd12,
    L_ROR    = 4'd13
  } logic_cmd_e;

  // True when every operand the op needs is flagged valid
  function automatic logic operands_ok(input logic [1:0] have, input logic [1:0] need);
    return (have & need) == need;
  endfunction

endpackage

// File: rtl/modport_alu_if.sv
// Operand/command bus and registered result/flag bus of the ALU.
// Latency: n/a (wiring only).
// Backpressure: none; CE is the only stall mechanism.
interface modport_alu_if
  import modport_alu_pkg::*;
#(
  parameter int N = ALU_N,
  parameter int M = ALU_M
);

  logic         CE;
  logic         MODE;
  logic [M-1:0] CMD;
  logic [1:0]   INP_VALID;
  logic [N-1:0] OPA;
  logic [N-1:0] OPB;
  logic         CIN;
  logic [N:0]   RES;
  logic         COUT;
  logic         OFLOW;
  logic         E;
  logic         G;
  logic         L;
  logic         ERR;

  modport master (
    output CE, MODE, CMD, INP_VALID, OPA, OPB, CIN,
    input  RES, COUT, OFLOW, E, G, L, ERR
  );

  modport slave (
    input  CE, MODE, CMD, INP_VALID, OPA, OPB, CIN,
    output RES, COUT, OFLOW, E, G, L, ERR
  );

endinterface

// File: rtl/modport_alu_mul.sv
// Multiply stage: captures (A+1)*(B+1) or (A<<1)*B, truncated to N+1 bits.
// Latency: product held here one CE cycle; the top registers it on the next CE edge.
// Backpressure: ce=0 holds the product and the pending flag.
module modport_alu_mul
  import modport_alu_pkg::*;
#(
  parameter int N = ALU_N
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         ce,
  input  logic         start,
  input  logic         sel_shl,
  input  logic [N-1:0] opa,
  input  logic [N-1:0] opb,
  output logic         busy,
  output logic [N:0]   prod
);

  localparam logic [N:0] ONE = (N+1)'(1);

  logic [N:0] fa;
  logic [N:0] fb;
  logic [N:0] prod_d;

  // Operand shaping; N+1-bit operands give an exactly truncated N+1-bit product
  always_comb begin
    fa = {1'b0, opa} + ONE;
    fb = {1'b0, opb} + ONE;
    if (sel_shl) begin
      fa = {opa, 1'b0};
      fb = {1'b0, opb};
    end
    prod_d = fa * fb;
  end

  // Pending stage: set at issue, cleared on the next CE edge when the top consumes it
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      busy <= 1'b0;
      prod <= '0;
    end else if (ce) begin
      if (busy) begin
        busy <= 1'b0;
      end else if (start) begin
        busy <= 1'b1;
        prod <= prod_d;
      end
    end
  end

endmodule

// File: rtl/modport_alu.sv
// Registered N-bit ALU: arithmetic and logic ops with operand-valid checks and flags.
// Latency: 1 CE edge for all ops, 2 CE edges for the multiply forms.
// Backpressure: none; CE=0 freezes all state, INP_VALID=00 is a hold cycle.
module modport_alu
  import modport_alu_pkg::*;
#(
  parameter int N = ALU_N,
  parameter int M = ALU_M
) (
  input  logic         CLK,
  input  logic         RST,
  modport_alu_if.slave alu
);

  localparam int         SW  = $clog2(N);
  localparam logic [N:0] ONE = (N+1)'(1);
  localparam logic [SW:0] NW = (SW+1)'(N);

  logic [N:0]    a_x, b_x, cin_x;
  logic [SW-1:0] amt;
  logic [N-1:0]  rol, ror;
  logic          issue, is_mul, mul_start, mul_busy;
  logic [N:0]    mul_prod;
  logic [1:0]    need;
  logic [N:0]    res_d;
  logic          cout_d, oflow_d, e_d, g_d, l_d, err_d;
  logic [N:0]    res_q;
  logic          cout_q, oflow_q, e_q, g_q, l_q, err_q;

  assign a_x   = {1'b0, alu.OPA};
  assign b_x   = {1'b0, alu.OPB};
  assign cin_x = {{N{1'b0}}, alu.CIN};
  assign amt   = alu.OPB[SW-1:0];
  assign ror   = N'({alu.OPA, alu.OPA} >> amt);
  assign rol   = N'({alu.OPA, alu.OPA} >> (NW - {1'b0, amt}));
  assign issue = alu.INP_VALID != IV_NONE;

  // Decode the op into next result/flags; operand violations override everything
  always_comb begin
    need    = IV_AB;
    res_d   = '0;
    cout_d  = 1'b0;
    oflow_d = 1'b0;
    e_d     = 1'b0;
    g_d     = 1'b0;
    l_d     = 1'b0;
    err_d   = 1'b0;
    is_mul  = 1'b0;
    if (alu.MODE) begin
      case (alu.CMD)
        A_ADD:     begin res_d = a_x + b_x; cout_d = res_d[N]; end
        A_SUB:     begin res_d = a_x - b_x; oflow_d = a_x < b_x; end
        A_ADD_CIN: begin res_d = a_x + b_x + cin_x; cout_d = res_d[N]; end
        A_SUB_CIN: begin res_d = a_x - b_x - cin_x; oflow_d = a_x < (b_x + cin_x); end
        A_INC_A:   begin need = IV_A; res_d = a_x + ONE; end
        A_DEC_A:   begin need = IV_A; res_d = a_x - ONE; end
        A_INC_B:   begin need = IV_B; res_d = b_x + ONE; end
        A_DEC_B:   begin need = IV_B; res_d = b_x - ONE; end
        A_CMP:     begin e_d = a_x == b_x; g_d = a_x > b_x; l_d = a_x < b_x; end
        A_MUL_INC,
        A_MUL_SHL: is_mul = 1'b1;
        default:   err_d = 1'b1;
      endcase
    end else begin
      case (alu.CMD)
        L_AND:    res_d = {1'b0, alu.OPA & alu.OPB};
        L_NAND:   res_d = {1'b0, ~(alu.OPA & alu.OPB)};
        L_OR:     res_d = {1'b0, alu.OPA | alu.OPB};
        L_NOR:    res_d = {1'b0, ~(alu.OPA | alu.OPB)};
        L_XOR:    res_d = {1'b0, alu.OPA ^ alu.OPB};
        L_XNOR:   res_d = {1'b0, ~(alu.OPA ^ alu.OPB)};
        L_NOT_A:  begin need = IV_A; res_d = {1'b0, ~alu.OPA}; end
        L_NOT_B:  begin need = IV_B; res_d = {1'b0, ~alu.OPB}; end
        L_SHR1_A: begin need = IV_A; res_d = {2'b00, alu.OPA[N-1:1]}; end
        L_SHL1_A: begin need = IV_A; res_d = {1'b0, alu.OPA[N-2:0], 1'b0}; end
        L_SHR1_B: begin need = IV_B; res_d = {2'b00, alu.OPB[N-1:1]}; end
        L_SHL1_B: begin need = IV_B; res_d = {1'b0, alu.OPB[N-2:0], 1'b0}; end
        // Out-of-range rotate amount flags ERR but still delivers the rotation
        L_ROL:    begin res_d = {1'b0, rol}; err_d = |alu.OPB[N-1:SW]; end
        L_ROR:    begin res_d = {1'b0, ror}; err_d = |alu.OPB[N-1:SW]; end
        default:  err_d = 1'b1;
      endcase
    end
    if (!operands_ok(alu.INP_VALID, need)) begin
      res_d   = '0;
      cout_d  = 1'b0;
      oflow_d = 1'b0;
      e_d     = 1'b0;
      g_d     = 1'b0;
      l_d     = 1'b0;
      err_d   = 1'b1;
      is_mul  = 1'b0;
    end
  end

  // A completing multiply owns its edge, so no new op may issue alongside it
  assign mul_start = alu.CE & issue & is_mul & ~mul_busy;

  modport_alu_mul #(.N(N)) u_mul (
    .CLK     (CLK),
    .RST     (RST),
    .ce      (alu.CE),
    .start   (mul_start),
    .sel_shl (alu.CMD == A_MUL_SHL),
    .opa     (alu.OPA),
    .opb     (alu.OPB),
    .busy    (mul_busy),
    .prod    (mul_prod)
  );

  // Output register: multiply completion first, else a non-multiply issue, else hold
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      res_q <= '0; cout_q <= 1'b0; oflow_q <= 1'b0;
      e_q <= 1'b0; g_q <= 1'b0; l_q <= 1'b0; err_q <= 1'b0;
    end else if (alu.CE) begin
      if (mul_busy) begin
        res_q <= mul_prod; cout_q <= 1'b0; oflow_q <= 1'b0;
        e_q <= 1'b0; g_q <= 1'b0; l_q <= 1'b0; err_q <= 1'b0;
      end else if (issue && !is_mul) begin
        res_q <= res_d; cout_q <= cout_d; oflow_q <= oflow_d;
        e_q <= e_d; g_q <= g_d; l_q <= l_d; err_q <= err_d;
      end
    end
  end

  assign alu.RES   = res_q;
  assign alu.COUT  = cout_q;
  assign alu.OFLOW = oflow_q;
  assign alu.E     = e_q;
  assign alu.G     = g_q;
  assign alu.L     = l_q;
  assign alu.ERR   = err_q;

endmodule

// File: tb/tb_modport_alu.sv
// Bench for modport_alu: directed scenarios then random ops against an integer model.
// Latency: expects results one CE edge after issue, two for multiplies.
// Backpressure: exercises CE=0 holds and INP_VALID=00 idle cycles.
module tb_modport_alu;

  typedef struct packed {
    logic [8:0] res;
    logic       cout, oflow, e, g, l, err;
  } exp_t;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  modport_alu_if bus ();

  modport_alu dut (
    .CLK (CLK),
    .RST (RST),
    .alu (bus)
  );

  int   n_assert = 0;
  int   n_fail   = 0;
  exp_t expv;
  bit   pend;
  logic [8:0] pend_res;

  // Behavioural reference: plain integer arithmetic modulo 512 / 256
  function automatic void model(input bit mode, input int cmd, input bit [1:0] iv,
                                input int a, input int b, input int cin,
                                output exp_t o, output bit is_mul);
    int s, need, k;
    o = '0; is_mul = 0; need = 3; s = 0; k = b % 8;
    if (mode) begin
      case (cmd)
        0: begin s = a + b; o.res = 9'(s % 512); o.cout = s > 255; end
        1: begin o.res = 9'((a - b + 512) % 512); o.oflow = a < b; end
        2: begin s = a + b + cin; o.res = 9'(s % 512); o.cout = s > 255; end
        3: begin o.res = 9'((a - b - cin + 512) % 512); o.oflow = a < b + cin; end
        4: begin need = 1; o.res = 9'((a + 1) % 512); end
        5: begin need = 1; o.res = 9'((a + 511) % 512); end
        6: begin need = 2; o.res = 9'((b + 1) % 512); end
        7: begin need = 2; o.res = 9'((b + 511) % 512); end
        8: begin o.e = a == b; o.g = a > b; o.l = a < b; end
        9: begin is_mul = 1; o.res = 9'(((a + 1) * (b + 1)) % 512); end
        10: begin is_mul = 1; o.res = 9'(((2 * a) * b) % 512); end
        default: o.err = 1;
      endcase
    end else begin
      case (cmd)
        0: o.res = 9'(a & b);
        1: o.res = 9'(~(a & b) & 255);
        2: o.res = 9'(a | b);
        3: o.res = 9'(~(a | b) & 255);
        4: o.res = 9'(a ^ b);
        5: o.res = 9'(~(a ^ b) & 255);
        6: begin need = 1; o.res = 9'(~a & 255); end
        7: begin need = 2; o.res = 9'(~b & 255); end
        8: begin need = 1; o.res = 9'(a / 2); end
        9: begin need = 1; o.res = 9'((a * 2) % 256); end
        10: begin need = 2; o.res = 9'(b / 2); end
        11: begin need = 2; o.res = 9'((b * 2) % 256); end
        12: begin o.res = 9'(((a << k) | (a >> (8 - k))) & 255); o.err = b >= 8; end
        13: begin o.res = 9'(((a >> k) | (a << (8 - k))) & 255); o.err = b >= 8; end
        default: o.err = 1;
      endcase
    end
    if ((int'(iv) & need) != need) begin
      o = '0; o.err = 1; is_mul = 0;
    end
  endfunction

  task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] want);
    n_assert++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".RES"},   bus.RES,          expv.res);
    chk({tag, ".COUT"},  9'(bus.COUT),     9'(expv.cout));
    chk({tag, ".OFLOW"}, 9'(bus.OFLOW),    9'(expv.oflow));
    chk({tag, ".E"},     9'(bus.E),        9'(expv.e));
    chk({tag, ".G"},     9'(bus.G),        9'(expv.g));
    chk({tag, ".L"},     9'(bus.L),        9'(expv.l));
    chk({tag, ".ERR"},   9'(bus.ERR),      9'(expv.err));
  endtask

  // Present one cycle of inputs, advance the model across the edge, then check
  task automatic step(input bit ce, input bit mode, input int cmd, input bit [1:0] iv,
                      input int a, input int b, input bit cin, input string tag);
    exp_t r;
    bit   m;
    @(negedge CLK);
    bus.CE = ce; bus.MODE = mode; bus.CMD = 4'(cmd); bus.INP_VALID = iv;
    bus.OPA = 8'(a); bus.OPB = 8'(b); bus.CIN = cin;
    if (ce) begin
      if (pend) begin
        expv = '0; expv.res = pend_res; pend = 0;
      end else if (iv != 2'b00) begin
        model(mode, cmd, iv, a, b, int'(cin), r, m);
        if (m) begin pend = 1; pend_res = r.res; end
        else expv = r;
      end
    end
    @(posedge CLK);
    #1;
    check_all(tag);
  endtask

  task automatic async_reset(input string tag);
    #2;
    RST = 1'b0;
    #1;
    expv = '0; pend = 0;
    check_all(tag);
    @(negedge CLK);
    bus.CE = 1'b0;
    RST = 1'b1;
  endtask

  initial begin
    expv = '0; pend = 0; pend_res = '0;
    RST = 1'b0;
    bus.CE = 1'b0; bus.MODE = 1'b0; bus.CMD = '0; bus.INP_VALID = 2'b00;
    bus.OPA = '0; bus.OPB = '0; bus.CIN = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    check_all("reset");
    @(negedge CLK);
    RST = 1'b1;

    step(1, 1, 0, 2'b11, 200, 100, 0, "add");
    chk("add.lit_res", bus.RES, 9'd300);
    chk("add.lit_cout", 9'(bus.COUT), 9'd1);

    step(1, 1, 3, 2'b11, 5, 5, 1, "sub_cin");
    chk("sub_cin.lit_res", bus.RES, 9'h1FF);
    chk("sub_cin.lit_oflow", 9'(bus.OFLOW), 9'd1);

    step(1, 1, 8, 2'b11, 7, 9, 0, "cmp_lt");
    chk("cmp_lt.lit_l", 9'(bus.L), 9'd1);
    step(1, 1, 8, 2'b11, 3, 3, 0, "cmp_eq");
    chk("cmp_eq.lit_e", 9'(bus.E), 9'd1);

    step(1, 1, 9, 2'b11, 3, 4, 0, "mul_issue");
    chk("mul_issue.lit_res", bus.RES, 9'd0);
    step(0, 0, 4, 2'b11, 99, 77, 1, "mul_ce_low");
    chk("mul_ce_low.lit_res", bus.RES, 9'd0);
    step(1, 0, 2, 2'b11, 55, 66, 0, "mul_done");
    chk("mul_done.lit_res", bus.RES, 9'd20);
    step(1, 1, 10, 2'b11, 200, 3, 0, "mul_shl_issue");
    step(1, 1, 0, 2'b00, 0, 0, 0, "mul_shl_done");

    step(1, 1, 6, 2'b01, 10, 20, 0, "inc_b_noval");
    chk("inc_b_noval.lit_err", 9'(bus.ERR), 9'd1);
    step(1, 1, 5, 2'b01, 0, 0, 0, "dec_a_wrap");
    chk("dec_a_wrap.lit_res", bus.RES, 9'h1FF);
    step(1, 0, 14, 2'b11, 1, 2, 0, "logic_illegal");
    chk("logic_illegal.lit_err", 9'(bus.ERR), 9'd1);
    step(1, 0, 12, 2'b11, 8'h81, 8'h11, 0, "rol_err");
    chk("rol_err.lit_res", bus.RES, 9'h003);
    step(1, 0, 13, 2'b11, 8'h81, 8'h02, 0, "ror");
    step(1, 0, 9, 2'b01, 8'hC3, 0, 0, "shl1_a");

    step(1, 0, 4, 2'b11, 8'hF0, 8'h0F, 0, "xor");
    chk("xor.lit_res", bus.RES, 9'h0FF);
    for (int i = 0; i < 3; i++)
      step(0, 1, $urandom_range(0, 15), 2'b11, $urandom_range(0, 255),
           $urandom_range(0, 255), 1, "ce_hold");
    async_reset("async_rst_hold");

    step(1, 1, 9, 2'b11, 9, 9, 0, "mul_before_rst");
    async_reset("async_rst_mul");
    step(1, 1, 0, 2'b00, 0, 0, 0, "mul_discarded");

    for (int i = 0; i < 400; i++) begin
      bit [1:0] iv;
      iv = ($urandom_range(0, 3) != 0) ? 2'b11 : 2'($urandom_range(0, 3));
      step($urandom_range(0, 9) != 0, 1'($urandom_range(0, 1)), $urandom_range(0, 15), iv,
           $urandom_range(0, 255), $urandom_range(0, 255), 1'($urandom_range(0, 1)), "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
